// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU sequencer.
// Op codes, FSM states and the default operand width.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_NOR = 2'b00,
        OP_XOR = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ALU_WIDTH = 8;

    function automatic logic is_arith(input op_t o);
        return (o == OP_ADD) || (o == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_serial_shreg.sv
// Parallel-load, right-shift register with serial input at the MSB.
// Load has priority over shift.
module alu_serial_shreg
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = d_i;
        end else if (shift_i) begin
            q_d = {sin_i, q_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer driving an external 1-bit ALU slice, LSB first.
// Define OVERFLOW_EN to add the registered signed-overflow output ovf.
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout_o,
`ifdef OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [1:0]       slice_op,
    input  logic             slice_s,
    input  logic             slice_cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    op_t              op_q, op_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_d;
    logic             load, shift;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;

    alu_serial_shreg #(.WIDTH(WIDTH)) u_a_sh (
        .clk(clk), .rst(rst), .load_i(load), .shift_i(shift),
        .d_i(a), .sin_i(1'b0), .q_o(a_sh)
    );

    alu_serial_shreg #(.WIDTH(WIDTH)) u_b_sh (
        .clk(clk), .rst(rst), .load_i(load), .shift_i(shift),
        .d_i(b), .sin_i(1'b0), .q_o(b_sh)
    );

    alu_serial_shreg #(.WIDTH(WIDTH)) u_r_sh (
        .clk(clk), .rst(rst), .load_i(load), .shift_i(shift),
        .d_i('0), .sin_i(slice_s), .q_o(r_sh)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = 1'b0;
        load     = 1'b0;
        shift    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    load    = 1'b1;
                    op_d    = op_t'(op);
                    carry_d = (op_t'(op) == OP_SUB);
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                shift   = 1'b1;
                carry_d = is_arith(op_q) ? slice_cout : 1'b0;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    result_d = {slice_s, r_sh[WIDTH-1:1]};
                    cout_d   = carry_d;
                    // carry_q is the carry into the MSB on the last bit
                    ovf_d    = is_arith(op_q) & (carry_q ^ slice_cout);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= OP_NOR;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

`ifdef OVERFLOW_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == RUN && cnt_q == LAST) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_d;
`endif

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign cout_o    = cout_q;
    assign slice_a   = busy & a_sh[0];
    assign slice_b   = busy & b_sh[0];
    assign slice_cin = busy & carry_q;
    assign slice_op  = op_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq with a behavioural 1-bit slice.
module tb_alu_serial_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic [1:0] op;
    logic       busy, done, cout_o;
    logic [7:0] result;
    logic       slice_a, slice_b, slice_cin;
    logic [1:0] slice_op;
    logic       slice_s, slice_cout;
`ifdef OVERFLOW_EN
    logic       ovf;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_serial_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a(a), .b(b), .op(op),
        .busy(busy), .done(done), .result(result), .cout_o(cout_o),
`ifdef OVERFLOW_EN
        .ovf(ovf),
`endif
        .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
        .slice_op(slice_op), .slice_s(slice_s), .slice_cout(slice_cout)
    );

    logic sb;
    always_comb begin
        sb         = slice_b;
        slice_s    = 1'b0;
        slice_cout = 1'b0;
        case (slice_op)
            2'b00: slice_s = ~(slice_a | slice_b);
            2'b01: slice_s = slice_a ^ slice_b;
            default: begin
                if (slice_op == 2'b11) sb = ~slice_b;
                slice_s    = slice_a ^ sb ^ slice_cin;
                slice_cout = (slice_a & sb) | (slice_a & slice_cin)
                           | (sb & slice_cin);
            end
        endcase
    end

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb,
                          input logic [1:0] top,
                          output int lat, output int bcnt);
        @(negedge clk);
        a = ta; b = tb; op = top; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; bcnt = 0;
        while (!done && lat < 30) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy, done, cout_o, result} !== 11'd0) begin
            bad++;
            $display("FAIL reset_out got=%h want=0",
                     {busy, done, cout_o, result});
        end
        total++;
        if ({slice_a, slice_b, slice_cin, slice_op} !== 5'd0) begin
            bad++;
            $display("FAIL reset_slice got=%b want=00000",
                     {slice_a, slice_b, slice_cin, slice_op});
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        int lat, bcnt;
        run_op(8'h5A, 8'h3C, 2'b10, lat, bcnt);
        total++;
        if (lat !== 9) begin
            bad++; $display("FAIL add_latency got=%0d want=9", lat);
        end
        total++;
        if (bcnt !== 8) begin
            bad++; $display("FAIL add_busy got=%0d want=8", bcnt);
        end
        total++;
        if ({cout_o, result} !== {1'b0, 8'h96}) begin
            bad++;
            $display("FAIL add_5a_3c got=%b/%h want=0/96", cout_o, result);
        end
`ifdef OVERFLOW_EN
        total++;
        if (ovf !== 1'b1) begin
            bad++; $display("FAIL add_5a_3c_ovf got=%b want=1", ovf);
        end
`endif
        run_op(8'hFF, 8'h01, 2'b10, lat, bcnt);
        total++;
        if ({cout_o, result} !== {1'b1, 8'h00}) begin
            bad++;
            $display("FAIL add_ff_01 got=%b/%h want=1/00", cout_o, result);
        end
`ifdef OVERFLOW_EN
        total++;
        if (ovf !== 1'b0) begin
            bad++; $display("FAIL add_ff_01_ovf got=%b want=0", ovf);
        end
`endif
        run_op(8'h7F, 8'h01, 2'b10, lat, bcnt);
        total++;
        if ({cout_o, result} !== {1'b0, 8'h80}) begin
            bad++;
            $display("FAIL add_7f_01 got=%b/%h want=0/80", cout_o, result);
        end
`ifdef OVERFLOW_EN
        total++;
        if (ovf !== 1'b1) begin
            bad++; $display("FAIL add_7f_01_ovf got=%b want=1", ovf);
        end
`endif
        @(posedge clk); #1;
        total++;
        if ({done, result} !== {1'b0, 8'h80}) begin
            bad++;
            $display("FAIL hold_result got=%b/%h want=0/80", done, result);
        end
    endtask

    task automatic test_sub();
        int lat, bcnt;
        run_op(8'h10, 8'h01, 2'b11, lat, bcnt);
        total++;
        if ({cout_o, result} !== {1'b1, 8'h0F}) begin
            bad++;
            $display("FAIL sub_10_01 got=%b/%h want=1/0f", cout_o, result);
        end
        run_op(8'h00, 8'h01, 2'b11, lat, bcnt);
        total++;
        if ({cout_o, result} !== {1'b0, 8'hFF}) begin
            bad++;
            $display("FAIL sub_00_01 got=%b/%h want=0/ff", cout_o, result);
        end
`ifdef OVERFLOW_EN
        total++;
        if (ovf !== 1'b0) begin
            bad++; $display("FAIL sub_00_01_ovf got=%b want=0", ovf);
        end
`endif
    endtask

    task automatic test_logic();
        int lat, bcnt;
        run_op(8'hF0, 8'hAA, 2'b01, lat, bcnt);
        total++;
        if ({cout_o, result} !== {1'b0, 8'h5A}) begin
            bad++;
            $display("FAIL xor_f0_aa got=%b/%h want=0/5a", cout_o, result);
        end
        run_op(8'h0F, 8'hF0, 2'b00, lat, bcnt);
        total++;
        if ({cout_o, result} !== {1'b0, 8'h00}) begin
            bad++;
            $display("FAIL nor_0f_f0 got=%b/%h want=0/00", cout_o, result);
        end
        run_op(8'h00, 8'h00, 2'b00, lat, bcnt);
        total++;
        if ({cout_o, result} !== {1'b0, 8'hFF}) begin
            bad++;
            $display("FAIL nor_00_00 got=%b/%h want=0/ff", cout_o, result);
        end
`ifdef OVERFLOW_EN
        total++;
        if (ovf !== 1'b0) begin
            bad++; $display("FAIL nor_ovf got=%b want=0", ovf);
        end
`endif
    endtask

    task automatic test_ignore();
        int lat;
        @(negedge clk);
        a = 8'h12; b = 8'h34; op = 2'b10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 30) begin
            if (lat == 3) begin
                a = 8'hFF; b = 8'hFF; op = 2'b11; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        total++;
        if (lat !== 9) begin
            bad++; $display("FAIL ignore_latency got=%0d want=9", lat);
        end
        total++;
        if ({cout_o, result} !== {1'b0, 8'h46}) begin
            bad++;
            $display("FAIL ignore_result got=%b/%h want=0/46", cout_o, result);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL ignore_idle got=%b want=0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        a = 8'h01; b = 8'h02; op = 2'b10; start = 1'b1;
        @(posedge clk); #1;
        a = 8'h30; b = 8'h0C; op = 2'b01;
        lat = 1;
        while (!done && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if ({lat[3:0], result} !== {4'd9, 8'h03}) begin
            bad++;
            $display("FAIL b2b_first got=%0d/%h want=9/03", lat, result);
        end
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL b2b_accept got=%b want=1", busy);
        end
        while (!done && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if ({lat[4:0], cout_o, result} !== {5'd9, 1'b0, 8'h3C}) begin
            bad++;
            $display("FAIL b2b_second got=%0d/%b/%h want=9/0/3c",
                     lat, cout_o, result);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; op = 2'b10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (lat < 4) begin
            @(posedge clk); #1;
            lat++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({busy, done, result} !== 10'd0) begin
            bad++;
            $display("FAIL rst_mid got=%b/%b/%h want=0/0/00",
                     busy, done, result);
        end
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        total++;
        if ({seen[3:0], result} !== 12'd0) begin
            bad++;
            $display("FAIL rst_no_done got=%0d/%h want=0/00", seen, result);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
